// File: rtl/alu_pkg.sv
`default_nettype none
// alu_pkg: op codes and the reference bitwise function shared by the word-gate checkers.
// Rev 1.0
package alu_pkg;

  localparam int DEFAULT_W = 64;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOR = 2'b11;

  // Bitwise, so narrower users can zero-extend operands and truncate the result.
  function automatic logic [DEFAULT_W-1:0] calc_logic(
    input logic [1:0]           op,
    input logic [DEFAULT_W-1:0] a,
    input logic [DEFAULT_W-1:0] b
  );
    case (op)
      OP_AND:  calc_logic = a & b;
      OP_OR:   calc_logic = a | b;
      OP_XOR:  calc_logic = a ^ b;
      default: calc_logic = ~(a | b);
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_delay_line.sv
`default_nettype none
// alu_delay_line: DEPTH-stage shift register with per-stage valid; DEPTH=0 is a wire.
// Rev 1.0
module alu_delay_line #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_pipe
      logic [DEPTH-1:0] vld;
      logic [WIDTH-1:0] dat [DEPTH];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld <= '0;
          for (int i = 0; i < DEPTH; i++) dat[i] <= '0;
        end else begin
          vld[0] <= in_valid;
          dat[0] <= in_data;
          for (int i = 1; i < DEPTH; i++) begin
            vld[i] <= vld[i-1];
            dat[i] <= dat[i-1];
          end
        end
      end

      assign out_valid = vld[DEPTH-1];
      assign out_data  = dat[DEPTH-1];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/logic_result_checker.sv
`default_nettype none
// logic_result_checker: delays stimulus by LAT, compares DUT result, keeps counts and first-fail capture.
// Rev 1.0
module logic_result_checker
  import alu_pkg::*;
#(
  parameter int W     = DEFAULT_W,
  parameter int LAT   = 1,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_0,
  input  logic [W-1:0]     in_1,
  input  logic [1:0]       op,
  input  logic [W-1:0]     dut_res,
  input  logic             clear,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             err,
  output logic [CNT_W-1:0] fail_idx,
  output logic [W-1:0]     fail_exp,
  output logic [W-1:0]     fail_got
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             dv;
  logic [2*W+1:0]   d_bus;
  logic [W-1:0]     d_a;
  logic [W-1:0]     d_b;
  logic [1:0]       d_op;
  logic [W-1:0]     exp_res;
  logic             mismatch;
  logic [CNT_W-1:0] vec_idx;

  alu_delay_line #(
    .WIDTH (2*W+2),
    .DEPTH (LAT)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   ({op, in_1, in_0}),
    .out_valid (dv),
    .out_data  (d_bus)
  );

  assign {d_op, d_b, d_a} = d_bus;
  assign exp_res  = W'(calc_logic(d_op, DEFAULT_W'(d_a), DEFAULT_W'(d_b)));
  // Case inequality so an X/Z result in simulation is scored as a failure.
  assign mismatch = (dut_res !== exp_res);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      fail_idx <= '0;
      fail_exp <= '0;
      fail_got <= '0;
      vec_idx  <= '0;
    end else if (clear) begin
      pass_cnt <= '0;
      fail_cnt <= '0;
      err      <= 1'b0;
      fail_idx <= '0;
      fail_exp <= '0;
      fail_got <= '0;
      vec_idx  <= '0;
    end else if (dv) begin
      if (vec_idx != CNT_MAX) vec_idx <= vec_idx + CNT_ONE;
      if (mismatch) begin
        if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + CNT_ONE;
        err <= 1'b1;
        if (!err) begin
          fail_idx <= vec_idx;
          fail_exp <= exp_res;
          fail_got <= dut_res;
        end
      end else if (pass_cnt != CNT_MAX) begin
        pass_cnt <= pass_cnt + CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire
